// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer
// Posted-store buffer sitting between the MEM stage and the single data-cache
// port. Committed stores are queued in a circular FIFO and drained in order
// into the cache write channel. MEM-stage loads share the same port and get
// priority, except when the buffer is full, a write is already presented, or a
// flush is in progress. A load whose word address matches any buffered store
// (or a store accepted in the same cycle) is stalled until that store has been
// written, so the load-data path always reads up-to-date memory.

module dcache_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,

  // Store request from the pipeline (program-older than a same-cycle load)
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [3:0]       st_wstrb,
  input  logic [31:0]      st_wdata,
  output logic             st_ready,

  // Load request competing for the cache port
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_grant,
  output logic             ld_stall,

  // Drain-everything request (uncached access, CACHE op, sync)
  input  logic             flush_req,

  // Cache write channel
  output logic             cache_wr_valid,
  output logic [31:0]      cache_wr_addr,
  output logic [3:0]       cache_wr_wstrb,
  output logic [31:0]      cache_wr_wdata,
  input  logic             cache_wr_ready,

  // Occupancy
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    MODE_NORMAL,
    MODE_FLUSH
  } mode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [29:0]      r_addr [DEPTH];   // word address, bits [31:2]
  logic [3:0]       r_strb [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;            // per-entry valid, drives hazard compare
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_wr_hold;        // write presented last cycle, no handshake
  mode_e            r_mode;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic             w_full;
  logic             w_normal;
  logic             w_st_ready;
  logic             w_push;
  logic             w_entry_match;
  logic             w_hazard;
  logic             w_ld_grant;
  logic             w_wr_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_unused_addr_lsb;

  // Byte offsets never matter: storage and hazard compare are word-granular.
  assign w_unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0]};

  assign w_full     = (r_count == FULL_CNT);
  assign w_normal   = (r_mode == MODE_NORMAL);

  // Store acceptance looks only at registered state, never at a same-cycle pop.
  assign w_st_ready = !rst && w_normal && !w_full;
  assign w_push     = st_valid && w_st_ready;

  // Word-address match against every live entry.
  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional update; otherwise the tool infers a latch to hold the old value.
  always_comb begin
    w_entry_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr[i] == ld_addr[31:2])) begin
        w_entry_match = 1'b1;
      end
    end
  end

  // A store accepted this cycle is older than the load, so it counts too.
  assign w_hazard = ld_valid &&
                    (w_entry_match || (w_push && (st_addr[31:2] == ld_addr[31:2])));

  // Load wins the port unless it hazards, the buffer is full (drain must make
  // progress), or a write is already on the port waiting for its handshake.
  assign w_ld_grant = !rst && w_normal && ld_valid && !w_hazard && !w_full && !r_wr_hold;

  assign w_wr_valid = !rst && (r_count != '0) && !w_ld_grant;
  assign w_pop      = w_wr_valid && cache_wr_ready;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Entry payload write at the tail.
  // NOTE: the payload array has no reset; r_vld qualifies every entry, so
  // clearing the data would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr[31:2];
      r_strb[r_tail] <= st_wstrb;
      r_data[r_tail] <= st_wdata;
    end
  end

  // Pointers, occupancy, entry valids and the write-hold flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_vld     <= '0;
      r_wr_hold <= 1'b0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PTR_W'(1);
      end
      r_count   <= w_count_nxt;
      r_wr_hold <= w_wr_valid && !cache_wr_ready;
    end
  end

  // Mode FSM: a flush blocks stores and loads until the buffer has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_NORMAL;
    end else begin
      case (r_mode)
        MODE_NORMAL: begin
          if (flush_req && (w_count_nxt != '0)) begin
            r_mode <= MODE_FLUSH;
          end
        end
        MODE_FLUSH: begin
          if (w_count_nxt == '0) begin
            r_mode <= MODE_NORMAL;
          end
        end
        default: r_mode <= MODE_NORMAL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign st_ready       = w_st_ready;
  assign ld_grant       = w_ld_grant;
  assign ld_stall       = ld_valid && !w_ld_grant;

  assign cache_wr_valid = w_wr_valid;
  assign cache_wr_addr  = {r_addr[r_head], 2'b00};
  assign cache_wr_wstrb = r_strb[r_head];
  assign cache_wr_wdata = r_data[r_head];

  assign empty          = (r_count == '0);
  assign count          = r_count;

endmodule
